// File: rtl/pe_mac_engine.sv
// pe_mac_engine: systolic-array PE running an L-step signed MAC over local filter/ifmap scratchpads, with optional neighbour psum fold-in.
// Latency: start in cycle T -> psum_out_valid in cycle T+L+4; one more cycle, plus any psum_in stall, when fold-in is enabled.
// Backpressure: waits in WAIT_IN for psum_in_valid; holds psum_out stable in OUT until psum_out_ready.
module pe_mac_engine #(
   parameter int DATA_W      = 8,
   parameter int PSUM_W      = 20,
   parameter int FILT_DEPTH  = 64,
   parameter int IFMAP_DEPTH = 16,
   parameter int PSUM_DEPTH  = 16,
   parameter int FA_W        = $clog2(FILT_DEPTH),
   parameter int IA_W        = $clog2(IFMAP_DEPTH),
   parameter int PA_W        = $clog2(PSUM_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_filter,
   input  logic [FA_W-1:0]          ld_addr_filter,
   input  logic [DATA_W-1:0]        filter,
   input  logic                     load_ifmap,
   input  logic [IA_W-1:0]          ld_addr_ifmap,
   input  logic [DATA_W-1:0]        ifmap,
   input  logic                     start,
   input  logic [IA_W:0]            cfg_len,
   input  logic [FA_W-1:0]          cfg_filt_base,
   input  logic [IA_W-1:0]          cfg_ifmap_base,
   input  logic [PA_W-1:0]          cfg_psum_addr,
   input  logic                     cfg_acc_mode,
   input  logic                     cfg_psum_in_en,
   input  logic                     psum_in_valid,
   output logic                     psum_in_ready,
   input  logic signed [PSUM_W-1:0] psum_in,
   output logic                     psum_out_valid,
   input  logic                     psum_out_ready,
   output logic signed [PSUM_W-1:0] psum_out,
   output logic                     busy,
   output logic                     done
);

   localparam int LEN_W  = IA_W + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
   localparam logic signed [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_DRAIN1, S_DRAIN2, S_WAIT_IN, S_WB, S_OUT
   } state_t;

   state_t state, state_nxt;

   // Captured pass configuration
   logic [LEN_W-1:0] len_q;
   logic [FA_W-1:0]  filt_base_q;
   logic [IA_W-1:0]  ifmap_base_q;
   logic [PA_W-1:0]  psum_addr_q;
   logic             acc_mode_q;
   logic             in_en_q;

   logic [LEN_W-1:0] cnt;
   logic             start_ok;
   logic             load_ok;
   logic [FA_W-1:0]  filt_addr;
   logic [IA_W-1:0]  ifmap_addr;

   logic signed [DATA_W-1:0] filt_mem  [FILT_DEPTH];
   logic signed [DATA_W-1:0] ifmap_mem [IFMAP_DEPTH];
   logic signed [PSUM_W-1:0] psum_mem  [PSUM_DEPTH];

   logic signed [DATA_W-1:0] filt_q, ifmap_q;
   logic signed [PSUM_W-1:0] psum_q;
   logic signed [PROD_W-1:0] prod_q;
   logic signed [PSUM_W-1:0] acc;
   logic                     rd_vld, init_vld, prod_vld;

   // Lengths outside 1..IFMAP_DEPTH never leave IDLE
   assign start_ok   = start && (cfg_len != '0) && (cfg_len <= LEN_W'(IFMAP_DEPTH));
   assign load_ok    = rst && (state == S_IDLE);
   assign filt_addr  = filt_base_q + FA_W'(cnt);
   assign ifmap_addr = ifmap_base_q + cnt[IA_W-1:0];

   function automatic logic signed [PSUM_W-1:0] sat_add(input logic signed [PSUM_W-1:0] a,
                                                        input logic signed [PSUM_W-1:0] b);
      logic signed [PSUM_W:0] s;
      s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
      if (s[PSUM_W] != s[PSUM_W-1]) return s[PSUM_W] ? SAT_MIN : SAT_MAX;
      return s[PSUM_W-1:0];
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start_ok) state_nxt = S_MAC;
         S_MAC:     if (cnt == len_q - LEN_W'(1)) state_nxt = S_DRAIN1;
         S_DRAIN1:  state_nxt = S_DRAIN2;
         S_DRAIN2:  state_nxt = in_en_q ? S_WAIT_IN : S_WB;
         S_WAIT_IN: if (psum_in_valid) state_nxt = S_WB;
         S_WB:      state_nxt = S_OUT;
         S_OUT:     if (psum_out_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      busy           = (state != S_IDLE);
      psum_in_ready  = (state == S_WAIT_IN);
      psum_out_valid = (state == S_OUT);
      done           = (state == S_OUT) && psum_out_ready;
   end

   // Configuration capture on an accepted start
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start_ok) begin
         len_q        <= cfg_len;
         filt_base_q  <= cfg_filt_base;
         ifmap_base_q <= cfg_ifmap_base;
         psum_addr_q  <= cfg_psum_addr;
         acc_mode_q   <= cfg_acc_mode;
         in_en_q      <= cfg_psum_in_en;
      end
   end

   // MAC step counter
   always_ff @(posedge clk) begin
      if (!rst)                            cnt <= '0;
      else if (state == S_IDLE && start_ok) cnt <= '0;
      else if (state == S_MAC)             cnt <= cnt + LEN_W'(1);
   end

   // Filter/ifmap scratchpads: loads only in IDLE, synchronous read; contents survive reset
   always_ff @(posedge clk) begin
      if (load_ok && load_filter) filt_mem[ld_addr_filter] <= filter;
      if (load_ok && load_ifmap)  ifmap_mem[ld_addr_ifmap] <= ifmap;
      filt_q  <= filt_mem[filt_addr];
      ifmap_q <= ifmap_mem[ifmap_addr];
   end

   // Psum scratchpad: cleared by reset, written in WB, read continuously at the captured address
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < PSUM_DEPTH; i++) psum_mem[i] <= '0;
         psum_q <= '0;
      end else begin
         if (state == S_WB) psum_mem[psum_addr_q] <= acc;
         psum_q <= psum_mem[psum_addr_q];
      end
   end

   // Read -> product -> accumulate pipeline; init lands one cycle before the first product
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_vld   <= 1'b0;
         init_vld <= 1'b0;
         prod_vld <= 1'b0;
         prod_q   <= '0;
         acc      <= '0;
         psum_out <= '0;
      end else begin
         rd_vld   <= (state == S_MAC);
         init_vld <= (state == S_MAC) && (cnt == '0);
         prod_vld <= rd_vld;
         prod_q   <= filt_q * ifmap_q;
         if (state == S_IDLE && start_ok)              acc <= '0;
         else if (init_vld)                            acc <= acc_mode_q ? psum_q : '0;
         else if (prod_vld)                            acc <= sat_add(acc, PSUM_W'(prod_q));
         else if (state == S_WAIT_IN && psum_in_valid) acc <= sat_add(acc, psum_in);
         if (state == S_WB)                            psum_out <= acc;
         else if (state == S_OUT && psum_out_ready)    psum_out <= '0;
      end
   end

endmodule

// File: doc/pe_mac_engine.md
Name: pe_mac_engine

Overview:
- Parametrised next-generation processing element (PE) for the systolic array. It holds local filter, ifmap and partial-sum (psum) scratchpads.
- Runs a configurable-length signed multiply-accumulate (MAC) sequence under an FSM.
- Optionally folds in a psum from the neighbouring PE over a valid/ready handshake.
- Writes the result back to its psum scratchpad and emits it downstream over a valid/ready handshake.

Parameters:
- DATA_W, 8, ifmap/filter element width (signed two's complement)
- PSUM_W, 20, psum/accumulator width (signed); must be >= 2*DATA_W
- FILT_DEPTH, 64, filter scratchpad entries (power of 2)
- IFMAP_DEPTH, 16, ifmap scratchpad entries (power of 2)
- PSUM_DEPTH, 16, psum scratchpad entries (power of 2)
- FA_W/IA_W/PA_W, log2 of the respective depths (derived localparams)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- load_filter  in  1  write filter[ld_addr_filter] <= filter (honoured in IDLE only)
- ld_addr_filter  in  FA_W  filter load address
- filter  in  DATA_W  filter load data
- load_ifmap  in  1  write ifmap[ld_addr_ifmap] <= ifmap (IDLE only)
- ld_addr_ifmap  in  IA_W  ifmap load address
- ifmap  in  DATA_W  ifmap load data
- start  in  1  start pulse; sampled in IDLE only
- cfg_len  in  IA_W+1  MAC count L per pass (1..IFMAP_DEPTH)
- cfg_filt_base  in  FA_W  first filter address
- cfg_ifmap_base  in  IA_W  first ifmap address
- cfg_psum_addr  in  PA_W  psum entry used for init/writeback
- cfg_acc_mode  in  1  0: acc starts at 0; 1: acc starts at psum[cfg_psum_addr]
- cfg_psum_in_en  in  1  add the neighbour psum before writeback
- psum_in_valid  in  1  neighbour psum valid
- psum_in_ready  out  1  high only in state WAIT_IN
- psum_in  in  PSUM_W  neighbour psum (signed)
- psum_out_valid  out  1  result valid
- psum_out_ready  in  1  downstream ready
- psum_out  out  PSUM_W  result (signed)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the output handshake completes

Behaviour:
- Configuration: cfg_* are captured on the start edge and held internally for the whole pass.
- States: IDLE -> MAC -> DRAIN -> (WAIT_IN) -> WB -> OUT -> IDLE.
- IDLE: loads are accepted here. start with 1 <= L <= IFMAP_DEPTH moves to MAC. start with L=0 or L>IFMAP_DEPTH is ignored: no state change, no done.
- Scratchpads: synchronous read (data valid one cycle after the address) and synchronous write.
- MAC (L cycles), counter k = 0..L-1:
  - filter address = (cfg_filt_base + k) mod FILT_DEPTH
  - ifmap address = (cfg_ifmap_base + k) mod IFMAP_DEPTH
  - Read data is multiplied into a registered 2*DATA_W signed product, which is sign-extended and added to acc.
  - acc is initialised at MAC entry, to 0 or to psum[cfg_psum_addr] per cfg_acc_mode (read issued in the first MAC cycle, applied before the first product).
- DRAIN: 2 cycles, flushes the read and product pipeline.
- WAIT_IN: entered only when cfg_psum_in_en=1. psum_in_ready=1. When psum_in_valid & psum_in_ready, acc += psum_in, then go to WB.
- WB: 1 cycle. Writes psum[cfg_psum_addr] <= acc and loads the psum_out register.
- OUT: psum_out_valid=1 and psum_out is held stable until psum_out_ready. On the handshake cycle, done=1 and the next state is IDLE.
- Latency: start sampled in cycle T gives psum_out_valid first high in cycle T+L+4 (cfg_psum_in_en=0). With cfg_psum_in_en=1 and psum_in_valid already high on WAIT_IN entry, it is T+L+5.
- Arithmetic: every add (product, init and psum_in) saturates to the signed PSUM_W range, [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]. There is no wrap-around.
- Simultaneous events:
  - start and load in the same IDLE cycle: the load is performed, and MAC reads see the new data.
  - load_* or start while busy: ignored.
  - Both load strobes in the same cycle: both performed.
- Reset (rst=0 at an edge), including mid-operation:
  - state goes to IDLE
  - acc, psum_out, psum_out_valid, psum_in_ready, busy and done all go to 0
  - all psum scratchpad entries are cleared to 0
  - filter and ifmap contents are unchanged (undefined after power-up)
- psum_out is 0 whenever psum_out_valid=0.

Test Plan:
- Load filter[0..3]={1,2,3,4}, ifmap[0..3]={5,6,7,8}; start with L=4, bases 0, acc_mode=0, psum_in_en=0, psum_out_ready=1 -> psum_out=70 at T+8; psum[0]=70; done pulses once.
- Repeat the same pass with acc_mode=1, same psum addr -> psum_out=140. Then a pass with filter={-128}, ifmap={-128}, L=1 -> 16384 (no sign error).
- Wraparound: cfg_ifmap_base=14, L=4 -> ifmap addresses 14,15,0,1 are used; result matches the reference model.
- psum_in_en=1 with psum_in_valid held low for 5 cycles, then psum_in=-70 -> psum_in_ready is high throughout the stall, psum_out=0, latency extended by exactly 5.
- Saturation: preload psum entry = 2^19-100, acc_mode=1, product 127*127 -> psum_out=524287. Backpressure: psum_out_ready low for 3 cycles -> psum_out stable, done only on the handshake cycle.
- Reset asserted mid-MAC -> next cycle busy=0, psum_out_valid=0, psum entries read 0. start/load pulses while busy -> no effect on the result or memories.
